peridot_board_i2c_regif: RTL and testbench

I2C slave protocol layer sitting directly downstream of the PERIDOT board I2C byte engine (`peridot_board_i2c`). It decodes the 7-bit device address, a one-byte register pointer and data bytes from the byte/ack event stream. It turns them into single-byte Avalon-MM master reads and writes. It holds the byte engine's ACK phase, which stretches SCL, until each bus access completes.

---
 rtl/peridot_board_i2c_regif_pkg.sv | 28 ++
 rtl/peridot_board_i2c_regif_if.sv | 30 +++
 rtl/peridot_board_i2c_regif.sv | 188 ++++++++++++++++++
 tb/tb_peridot_board_i2c_regif.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peridot_board_i2c_regif_pkg.sv
// Shared constants for the PERIDOT I2C slave protocol layer:
// FSM encoding, ACK/NACK levels, idle byte and pointer helpers.
package peridot_i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DEVADDR = 3'd1,
      ST_REGADDR = 3'd2,
      ST_WRDATA  = 3'd3,
      ST_RDDATA  = 3'd4,
      ST_BUSWR   = 3'd5,
      ST_BUSRD   = 3'd6
   } regif_state_e;

   localparam logic       ACK_BIT   = 1'b1;
   localparam logic       NACK_BIT  = 1'b0;
   localparam logic [7:0] IDLE_BYTE = 8'hFF;

   // Register pointer advance; wraps 0xFF -> 0x00.
   function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
      return ptr + 8'd1;
   endfunction

   function automatic logic is_bus_state(input regif_state_e st);
      return (st == ST_BUSWR) || (st == ST_BUSRD);
   endfunction

endpackage

// File: rtl/peridot_board_i2c_regif_if.sv
// Single-byte Avalon-MM link between the I2C register interface (master)
// and the register file it accesses (slave).
interface peridot_board_i2c_regif_if;

   logic [7:0] avm_address;
   logic       avm_read;
   logic       avm_write;
   logic [7:0] avm_writedata;
   logic [7:0] avm_readdata;
   logic       avm_waitrequest;

   modport master (
      output avm_address,
      output avm_read,
      output avm_write,
      output avm_writedata,
      input  avm_readdata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_write,
      input  avm_writedata,
      output avm_readdata,
      output avm_waitrequest
   );

endinterface

// File: rtl/peridot_board_i2c_regif.sv
// I2C slave protocol layer: decodes address/pointer/data from the byte engine
// event stream and runs single-byte Avalon-MM accesses while stretching SCL.
module peridot_board_i2c_regif
   import peridot_i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = 7'h55
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              condi_start,
   input  logic                              condi_stop,
   input  logic                              done_byte,
   input  logic                              done_ack,
   input  logic [7:0]                        recieve_bytedata,
   input  logic                              recieve_ackdata,
   output logic                              ackwaitrequest,
   output logic                              send_ackdata,
   output logic [7:0]                        send_bytedata,
   output logic                              send_bytedatavalid,
   peridot_board_i2c_regif_if.master         avm
);

   regif_state_e state_q, state_d;
   logic [7:0]   ptr_q, ptr_d;
   logic [7:0]   addr_q, addr_d;
   logic [7:0]   wdata_q, wdata_d;
   logic [7:0]   sbyte_q, sbyte_d;
   logic         ack_q, ack_d;
   logic         sval_q, sval_d;
   logic         pstart_q, pstart_d;
   logic         pstop_q, pstop_d;
   logic         read_q, write_q, wait_q;

   // Next-state and next-output decode.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      sbyte_d  = sbyte_q;
      ack_d    = ack_q;
      sval_d   = sval_q;
      pstart_d = pstart_q;
      pstop_d  = pstop_q;

      case (state_q)
         ST_BUSWR, ST_BUSRD: begin
            // Bus conditions are only latched; the access must finish first.
            if (condi_start) begin
               pstart_d = 1'b1;
               pstop_d  = 1'b0;
            end else if (condi_stop) begin
               pstart_d = 1'b0;
               pstop_d  = 1'b1;
            end else begin
            end
            if (!avm.avm_waitrequest) begin
               if (state_q == ST_BUSWR) begin
                  ptr_d   = ptr_next(ptr_q);
                  state_d = ST_WRDATA;
               end else begin
                  sbyte_d = avm.avm_readdata;
                  sval_d  = 1'b1;
                  state_d = ST_RDDATA;
               end
               if (pstart_d) begin
                  state_d = ST_DEVADDR;
               end else if (pstop_d) begin
                  state_d = ST_IDLE;
               end else begin
               end
               pstart_d = 1'b0;
               pstop_d  = 1'b0;
            end else begin
            end
         end
         default: begin
            pstart_d = 1'b0;
            pstop_d  = 1'b0;
            if (condi_start) begin
               state_d = ST_DEVADDR;
            end else if (condi_stop) begin
               state_d = ST_IDLE;
            end else begin
               case (state_q)
                  ST_DEVADDR: begin
                     if (done_byte) begin
                        if (recieve_bytedata[7:1] != DEVICE_ADDR) begin
                           ack_d   = NACK_BIT;
                           state_d = ST_IDLE;
                        end else if (recieve_bytedata[0]) begin
                           ack_d   = ACK_BIT;
                           addr_d  = ptr_q;
                           state_d = ST_BUSRD;
                        end else begin
                           ack_d   = ACK_BIT;
                           state_d = ST_REGADDR;
                        end
                     end else begin
                     end
                  end
                  ST_REGADDR: begin
                     if (done_byte) begin
                        ptr_d   = recieve_bytedata;
                        ack_d   = ACK_BIT;
                        state_d = ST_WRDATA;
                     end else begin
                     end
                  end
                  ST_WRDATA: begin
                     if (done_byte) begin
                        addr_d  = ptr_q;
                        wdata_d = recieve_bytedata;
                        ack_d   = ACK_BIT;
                        state_d = ST_BUSWR;
                     end else begin
                     end
                  end
                  ST_RDDATA: begin
                     // Prefetch the next byte as soon as the current one is out.
                     if (done_byte) begin
                        ptr_d   = ptr_next(ptr_q);
                        addr_d  = ptr_next(ptr_q);
                        state_d = ST_BUSRD;
                     end else if (done_ack && !recieve_ackdata) begin
                        sval_d  = 1'b0;
                        state_d = ST_IDLE;
                     end else begin
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      endcase

      if ((state_d == ST_IDLE) || (state_d == ST_DEVADDR)) begin
         sval_d = 1'b0;
      end else begin
      end
      if (state_d == ST_IDLE) begin
         ack_d = NACK_BIT;
      end else begin
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 8'h00;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
         sbyte_q  <= IDLE_BYTE;
         ack_q    <= NACK_BIT;
         sval_q   <= 1'b0;
         pstart_q <= 1'b0;
         pstop_q  <= 1'b0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         wait_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         sbyte_q  <= sbyte_d;
         ack_q    <= ack_d;
         sval_q   <= sval_d;
         pstart_q <= pstart_d;
         pstop_q  <= pstop_d;
         read_q   <= (state_d == ST_BUSRD);
         write_q  <= (state_d == ST_BUSWR);
         wait_q   <= is_bus_state(state_d);
      end
   end

   assign avm.avm_address    = addr_q;
   assign avm.avm_read       = read_q;
   assign avm.avm_write      = write_q;
   assign avm.avm_writedata  = wdata_q;
   assign ackwaitrequest     = wait_q;
   assign send_ackdata       = ack_q;
   assign send_bytedata      = sbyte_q;
   assign send_bytedatavalid = sval_q;

endmodule

// File: tb/tb_peridot_board_i2c_regif.sv
// Scoreboard bench for peridot_board_i2c_regif: emulates the byte engine and
// an Avalon register file with programmable wait states.
module tb_peridot_board_i2c_regif;

   logic       clk;
   logic       reset_n;
   logic       condi_start, condi_stop, done_byte, done_ack;
   logic [7:0] recieve_bytedata;
   logic       recieve_ackdata;
   logic       ackwaitrequest, send_ackdata, send_bytedatavalid;
   logic [7:0] send_bytedata;

   peridot_board_i2c_regif_if avm_if ();

   peridot_board_i2c_regif #(.DEVICE_ADDR(7'h55)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .condi_start        (condi_start),
      .condi_stop         (condi_stop),
      .done_byte          (done_byte),
      .done_ack           (done_ack),
      .recieve_bytedata   (recieve_bytedata),
      .recieve_ackdata    (recieve_ackdata),
      .ackwaitrequest     (ackwaitrequest),
      .send_ackdata       (send_ackdata),
      .send_bytedata      (send_bytedata),
      .send_bytedatavalid (send_bytedatavalid),
      .avm                (avm_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [16:0] exp_bus[$];
   int          exp_pulse[$];
   logic        exp_ack[$];
   logic [8:0]  exp_tx[$];
   logic [28:0] exp_snap[$];
   logic        ack_chk = 1'b0, tx_chk = 1'b0, snap_chk = 1'b0;

   // Avalon register file with stall_cfg wait states per access
   logic [7:0] mem [256];
   int         stall_cfg = 0;
   int         stall_left = 0;
   assign avm_if.avm_waitrequest = (avm_if.avm_read || avm_if.avm_write) && (stall_left != 0);
   assign avm_if.avm_readdata    = mem[avm_if.avm_address];

   always @(posedge clk) begin
      if (!reset_n) begin
         mem[8'hFF] <= 8'h11;
         mem[8'h00] <= 8'h22;
         mem[8'h01] <= 8'h33;
         mem[8'h02] <= 8'h44;
         mem[8'h20] <= 8'h77;
      end
      if (avm_if.avm_read || avm_if.avm_write) begin
         if (stall_left != 0) stall_left <= stall_left - 1;
         else if (avm_if.avm_write) mem[avm_if.avm_address] <= avm_if.avm_writedata;
      end else begin
         stall_left <= stall_cfg;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents an observable event
   int          pulse_cnt = 0;
   logic        stall_prev = 1'b0, stab_err = 1'b0;
   logic [17:0] stall_snap;
   always @(negedge clk) begin : mon
      logic        req;
      logic [16:0] got, e_bus;
      logic [17:0] cur;
      logic        e_ack;
      logic [8:0]  e_tx;
      logic [28:0] e_snap;
      req = avm_if.avm_read || avm_if.avm_write;
      cur = {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata};
      if (!reset_n) begin
         pulse_cnt  = 0;
         stall_prev = 1'b0;
         stab_err   = 1'b0;
      end else begin
         if (ackwaitrequest) begin
            pulse_cnt++;
         end else if (pulse_cnt != 0) begin
            if (exp_pulse.size() == 0) chk("ackwait_pulse_unexpected", 32'(pulse_cnt), 32'd0);
            else chk("ackwait_pulse_len", 32'(pulse_cnt), 32'(exp_pulse.pop_front()));
            pulse_cnt = 0;
         end
         if (req && avm_if.avm_waitrequest) begin
            if (stall_prev && (cur != stall_snap)) stab_err = 1'b1;
            stall_snap = cur;
            stall_prev = 1'b1;
         end else if (req) begin
            if (stall_prev) begin
               if (cur != stall_snap) stab_err = 1'b1;
               chk("request_stable_during_stall", 32'(stab_err), 32'd0);
            end
            got = {avm_if.avm_write, avm_if.avm_address,
                   avm_if.avm_write ? avm_if.avm_writedata : 8'h00};
            if (exp_bus.size() == 0) begin
               chk("bus_unexpected", {15'd1, got}, 32'd0);
            end else begin
               e_bus = exp_bus.pop_front();
               chk("bus_access", 32'(got), 32'(e_bus));
            end
            stall_prev = 1'b0;
            stab_err   = 1'b0;
         end else begin
            stall_prev = 1'b0;
         end
      end
      if (ack_chk) begin
         e_ack = exp_ack.pop_front();
         chk("send_ackdata", 32'(send_ackdata), 32'(e_ack));
      end
      if (tx_chk) begin
         e_tx = exp_tx.pop_front();
         chk("send_byte", 32'({send_bytedatavalid, send_bytedata}), 32'(e_tx));
      end
      if (snap_chk) begin
         e_snap = exp_snap.pop_front();
         chk("snapshot", 32'({ackwaitrequest, send_ackdata, send_bytedatavalid,
                              avm_if.avm_read, avm_if.avm_write, send_bytedata,
                              avm_if.avm_address, avm_if.avm_writedata}), 32'(e_snap));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      condi_start = 1'b1;
      step();
      condi_start = 1'b0;
   endtask

   task automatic pulse_stop();
      condi_stop = 1'b1;
      step();
      condi_stop = 1'b0;
   endtask

   task automatic exp_access(input logic we, input logic [7:0] a, input logic [7:0] d, input int len);
      exp_bus.push_back({we, a, we ? d : 8'h00});
      exp_pulse.push_back(len);
   endtask

   // Byte received: ACK decision is checked in the cycle after done_byte
   task automatic send_byte(input logic [7:0] b, input logic do_chk, input logic e_ack);
      recieve_bytedata = b;
      done_byte = 1'b1;
      if (do_chk) exp_ack.push_back(e_ack);
      step();
      done_byte = 1'b0;
      ack_chk = do_chk;
      step();
      ack_chk = 1'b0;
   endtask

   task automatic wait_release();
      int n = 0;
      while (ackwaitrequest && n < 200) begin
         step();
         n++;
      end
      chk("ackwait_release", 32'(ackwaitrequest), 32'd0);
   endtask

   task automatic ack_end(input logic ackbit, input logic do_tx, input logic e_v, input logic [7:0] e_d);
      step();
      step();
      recieve_ackdata = ackbit;
      done_ack = 1'b1;
      if (do_tx) exp_tx.push_back({e_v, e_d});
      tx_chk = do_tx;
      step();
      done_ack = 1'b0;
      tx_chk = 1'b0;
      recieve_ackdata = 1'b1;
      step();
   endtask

   task automatic wr(input logic [7:0] b, input logic e_ack);
      send_byte(b, 1'b1, e_ack);
      wait_release();
      ack_end(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic rd_byte(input logic mack, input logic e_v, input logic [7:0] e_d);
      send_byte(8'h00, 1'b0, 1'b0);
      wait_release();
      ack_end(mack, 1'b1, e_v, e_d);
   endtask

   task automatic snap(input logic [28:0] e);
      exp_snap.push_back(e);
      snap_chk = 1'b1;
      step();
      snap_chk = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      condi_start = 1'b0;
      condi_stop = 1'b0;
      done_byte = 1'b0;
      done_ack = 1'b0;
      recieve_bytedata = 8'h00;
      recieve_ackdata = 1'b1;
      repeat (3) step();
      snap({5'b00000, 8'hFF, 8'h00, 8'h00});
      reset_n = 1'b1;
      step();

      // Two-byte write with auto-increment, zero wait
      pulse_start();
      wr(8'hAA, 1'b1);
      wr(8'h10, 1'b1);
      exp_access(1'b1, 8'h10, 8'hA5, 1);
      wr(8'hA5, 1'b1);
      exp_access(1'b1, 8'h11, 8'h3C, 1);
      wr(8'h3C, 1'b1);
      pulse_stop();
      step();

      // Address mismatch, then everything NACKed until START
      pulse_start();
      wr(8'h54, 1'b0);
      wr(8'hAA, 1'b0);
      pulse_stop();
      step();

      // Pointer 0xFF, repeated START, read three bytes across the wrap
      pulse_start();
      wr(8'hAA, 1'b1);
      wr(8'hFF, 1'b1);
      pulse_start();
      exp_access(1'b0, 8'hFF, 8'h00, 1);
      send_byte(8'hAB, 1'b1, 1'b1);
      wait_release();
      ack_end(1'b1, 1'b1, 1'b1, 8'h11);
      exp_access(1'b0, 8'h00, 8'h00, 1);
      rd_byte(1'b1, 1'b1, 8'h22);
      exp_access(1'b0, 8'h01, 8'h00, 1);
      rd_byte(1'b1, 1'b1, 8'h33);
      exp_access(1'b0, 8'h02, 8'h00, 1);
      rd_byte(1'b0, 1'b1, 8'h44);
      snap({5'b00000, 8'h44, 8'h02, 8'h3C});
      pulse_stop();
      step();

      // Write stalled for 20 cycles
      pulse_start();
      wr(8'hAA, 1'b1);
      wr(8'h40, 1'b1);
      stall_cfg = 20;
      exp_access(1'b1, 8'h40, 8'h5A, 21);
      wr(8'h5A, 1'b1);
      stall_cfg = 0;
      pulse_stop();
      step();

      // STOP during a stalled read: read completes, then idle
      pulse_start();
      wr(8'hAA, 1'b1);
      wr(8'h20, 1'b1);
      pulse_start();
      stall_cfg = 10;
      exp_access(1'b0, 8'h20, 8'h00, 11);
      send_byte(8'hAB, 1'b1, 1'b1);
      step();
      pulse_stop();
      stall_cfg = 0;
      wait_release();
      snap({5'b00000, 8'h77, 8'h20, 8'h5A});
      wr(8'hAA, 1'b0);

      // Reset during a stalled write
      pulse_start();
      wr(8'hAA, 1'b1);
      wr(8'h30, 1'b1);
      stall_cfg = 10;
      send_byte(8'h99, 1'b1, 1'b1);
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      stall_cfg = 0;
      snap({5'b00000, 8'hFF, 8'h00, 8'h00});
      wr(8'hAA, 1'b0);
      pulse_start();
      exp_access(1'b0, 8'h00, 8'h00, 1);
      send_byte(8'hAB, 1'b1, 1'b1);
      wait_release();
      ack_end(1'b1, 1'b1, 1'b1, 8'h22);
      exp_access(1'b0, 8'h01, 8'h00, 1);
      rd_byte(1'b0, 1'b1, 8'h33);
      pulse_stop();
      repeat (5) step();

      chk("bus_expectations_left", 32'(exp_bus.size()), 32'd0);
      chk("pulse_expectations_left", 32'(exp_pulse.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", n_checks, n_err);
      $fatal(1, "watchdog");
   end

endmodule
